// File: rtl/sync_fifo_wr_arbiter.sv
// sync_fifo_wr_arbiter: shares one sync FIFO write port among NUM_REQ producers.
// Grants are per packet. A grant ends on a beat with req_last or after BURST_MAX
// beats. The write path is registered, and the arbiter counts the write still in
// flight against fifo_cnt so that it never overflows the FIFO.
// Optional macro FIFO_ARB_FIXED_PRIO_EN switches the IDLE pick from round-robin
// to fixed priority, with requester 0 highest.
module sync_fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DATA_DEPTH = 8,
    parameter int unsigned BURST_MAX  = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0]              req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic                            fifo_full,
    input  logic [$clog2(DATA_DEPTH):0]     fifo_cnt,
    output logic                            fifo_wr_en,
    output logic [DATA_WIDTH-1:0]           fifo_data_in,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic                            busy
);

    localparam int unsigned CNT_W  = $clog2(DATA_DEPTH) + 1;
    localparam int unsigned SUM_W  = CNT_W + 1;
    localparam int unsigned ID_W   = $clog2(NUM_REQ);
    localparam int unsigned BEAT_W = $clog2(BURST_MAX + 1);

    typedef enum logic {StIdle, StBurst} state_e;

    state_e                 state;
    logic [BEAT_W-1:0]      beat_cnt;
`ifndef FIFO_ARB_FIXED_PRIO_EN
    logic [ID_W-1:0]        rr_ptr;
    logic [ID_W-1:0]        next_ptr;
`endif

    logic [DATA_WIDTH-1:0]  data_arr [NUM_REQ];
    logic [SUM_W-1:0]       occupancy;
    logic                   space_ok;
    logic                   sel_valid;
    logic                   sel_last;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic                   accept;
    logic                   last_beat;
    logic [ID_W-1:0]        pick;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Registered write still counts as occupied; reads are not credited.
    assign occupancy = SUM_W'(fifo_cnt) + SUM_W'(fifo_wr_en);
    assign space_ok  = (occupancy < SUM_W'(DATA_DEPTH)) && !fifo_full;

    assign sel_valid = req_valid[grant_id];
    assign sel_last  = req_last[grant_id];
    assign sel_data  = data_arr[grant_id];
    assign accept    = (state == StBurst) && sel_valid && space_ok;
    assign last_beat = sel_last || (beat_cnt == BEAT_W'(BURST_MAX - 1));

`ifndef FIFO_ARB_FIXED_PRIO_EN
    assign next_ptr = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
`endif

    // Only the current owner sees ready, and only while the FIFO has room.
    always_comb begin
        req_ready = '0;
        if (state == StBurst) begin
            req_ready[grant_id] = space_ok;
        end
    end

    // IDLE pick: next owner among the valid requesters.
`ifdef FIFO_ARB_FIXED_PRIO_EN
    always_comb begin
        logic found;
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[i]) begin
                pick  = ID_W'(i);
                found = 1'b1;
            end
        end
    end
`else
    always_comb begin
        logic        found;
        int unsigned idx;
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req_valid[idx]) begin
                pick  = ID_W'(idx);
                found = 1'b1;
            end
        end
    end
`endif

    // Grant FSM with registered FIFO write port; reset wins over any handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= StIdle;
            beat_cnt     <= '0;
            fifo_wr_en   <= 1'b0;
            fifo_data_in <= '0;
            grant_id     <= '0;
            busy         <= 1'b0;
`ifndef FIFO_ARB_FIXED_PRIO_EN
            rr_ptr       <= '0;
`endif
        end else begin
            case (state)
                StIdle: begin
                    fifo_wr_en <= 1'b0;
                    if (|req_valid) begin
                        grant_id <= pick;
                        busy     <= 1'b1;
                        state    <= StBurst;
                    end
                end
                StBurst: begin
                    fifo_wr_en <= accept;
                    if (accept) begin
                        fifo_data_in <= sel_data;
                        if (last_beat) begin
                            state    <= StIdle;
                            beat_cnt <= '0;
                            busy     <= 1'b0;
`ifndef FIFO_ARB_FIXED_PRIO_EN
                            rr_ptr   <= next_ptr;
`endif
                        end else begin
                            beat_cnt <= beat_cnt + BEAT_W'(1);
                        end
                    end
                end
                default: begin
                    state      <= StIdle;
                    fifo_wr_en <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
